frame_sequencer: RTL
====================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter IMAGE_WIDTH, default 768: pixels per row; SHALL be even and at least 2.
REQ-002 Parameter IMAGE_HEIGHT, default 512: rows per frame; at least 1.
REQ-003 Parameter VSYNC_CYCLES, default 100: frame-start pulse length in cycles; at least 1.
REQ-004 Parameter H_BLANK, default 160: blanking cycles before each row; at least 1.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  frame request; sampled only in IDLE.
REQ-008 stop  input  1  synchronous abort; honoured in any non-IDLE state.
REQ-009 vertical_Pulse  output  1  high throughout the VSYNC state.
REQ-010 horizontal_Pulse  output  1  high while a pixel pair is valid (DATA state); drives the BMP writer's horizontal_Pulse.
REQ-011 pixel_Addr  output  ADDR_W = clog2(IMAGE_WIDTH*IMAGE_HEIGHT)  linear address of the even pixel of the current pair; the odd pixel is pixel_Addr+1.
REQ-012 row  output  clog2(IMAGE_HEIGHT), minimum 1  current row index.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_Done  output  1  one-cycle pulse at frame completion; drives the writer's done path.

Function
REQ-015 States SHALL be IDLE, VSYNC, HBLANK, DATA and DONE, with all outputs registered.
REQ-016 In IDLE with start=1, the next state SHALL be VSYNC with a cycle counter cleared and row=0.
REQ-017 VSYNC SHALL last exactly VSYNC_CYCLES cycles and then go to HBLANK.
REQ-018 HBLANK SHALL last exactly H_BLANK cycles with horizontal_Pulse=0, then go to DATA.
REQ-019 DATA SHALL last exactly IMAGE_WIDTH/2 cycles.
REQ-020 In DATA, cycle c (0-based) SHALL present pixel_Addr = row*IMAGE_WIDTH + 2*c.
REQ-021 At the end of DATA: if row < IMAGE_HEIGHT-1, row increments and the state returns to HBLANK; otherwise the state goes to DONE.
REQ-022 DONE SHALL last one cycle with frame_Done=1, then go to IDLE.
REQ-023 Outside DATA, pixel_Addr SHALL hold its last value; it SHALL be 0 after reset.
REQ-024 Latency: frame_Done SHALL be high exactly 1 + VSYNC_CYCLES + IMAGE_HEIGHT*(H_BLANK + IMAGE_WIDTH/2) cycles after the edge that samples start.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 stop=1 in any non-IDLE state (including DONE) SHALL go to IDLE on the next edge.
REQ-027 On that stop transition, frame_Done SHALL stay 0 and the pulses SHALL go low.
REQ-028 If stop and start are both high in IDLE, start SHALL win.
REQ-029 Counter widths SHALL cover max(VSYNC_CYCLES, H_BLANK, IMAGE_WIDTH/2) without wrap.
REQ-030 Address arithmetic SHALL be ADDR_W bits wide, and the last address SHALL be IMAGE_WIDTH*IMAGE_HEIGHT-2.

Reset
REQ-031 On reset=0, asynchronously: state=IDLE, all counters=0, row=0, pixel_Addr=0.
REQ-032 On reset=0, asynchronously: vertical_Pulse, horizontal_Pulse, busy and frame_Done all 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no frame_Done; the block SHALL be ready for start on the first edge after reset deasserts.

Structure
REQ-034 The state encoding and the default image dimensions SHALL live in a shared image package, also used by the BMP writer and the reader.
REQ-035 One sub-module, cycle_counter (load, enable, terminal-count flag), SHALL be instantiated for the phase timing.
REQ-036 Row and address tracking SHALL stay in frame_sequencer.

Verification (IMAGE_WIDTH=8, IMAGE_HEIGHT=4, VSYNC_CYCLES=3, H_BLANK=2)
REQ-037 start pulse -> vertical_Pulse high 3 cycles; 4 bursts of 4 horizontal_Pulse cycles, each preceded by 2 low cycles; frame_Done 28 cycles after start sampled.
REQ-038 Full frame -> pixel_Addr sequence 0,2,4,6,8,...,30, row 0..3, no gaps or repeats.
REQ-039 start held high for the whole frame -> exactly one frame, then a new frame starts the cycle after returning to IDLE.
REQ-040 stop asserted in row 2, DATA cycle 1 -> IDLE next cycle, frame_Done never pulses, busy=0.
REQ-041 reset low during HBLANK of row 1 -> all outputs 0 immediately; a following start produces a full 28-cycle frame.
REQ-042 stop and start high together in IDLE -> frame starts, vertical_Pulse high next cycle.

Source files
------------

// File: rtl/image_pkg.sv
// Shared image definitions: sequencer state encoding and default frame geometry,
// common to the frame sequencer, the BMP writer and the reader.
package image_pkg;

  localparam int DEF_IMAGE_WIDTH  = 768;
  localparam int DEF_IMAGE_HEIGHT = 512;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_HBLANK = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Phase timer: clears on load, counts up while enabled, and flags when the
// count reaches the terminal value supplied for the current phase.
module cycle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign tc = (count_q == term);

endmodule

// File: rtl/frame_sequencer.sv
// Frame timing generator: VSYNC, then per row an HBLANK gap and a DATA burst of
// pixel pairs, then a one-cycle DONE; drives the BMP writer's sync and address.
module frame_sequencer
  import image_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int VSYNC_CYCLES = 100,
  parameter int H_BLANK      = 160,
  localparam int ADDR_W = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              vertical_Pulse,
  output logic              horizontal_Pulse,
  output logic [ADDR_W-1:0] pixel_Addr,
  output logic [ROW_W-1:0]  row,
  output logic              busy,
  output logic              frame_Done
);

  localparam int HALF_W  = IMAGE_WIDTH / 2;
  localparam int CNT_MAX = max3(VSYNC_CYCLES, H_BLANK, HALF_W);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] VSYNC_TERM  = CNT_W'(VSYNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] HBLANK_TERM = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] DATA_TERM   = CNT_W'(HALF_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(IMAGE_HEIGHT - 1);

  seq_state_e        state_q, state_d;
  logic              cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_term;
  logic [ADDR_W-1:0] row_base;

  cycle_counter #(.WIDTH(CNT_W)) u_phase_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .load   (cnt_load),
    .enable (cnt_en),
    .term   (cnt_term),
    .tc     (cnt_tc)
  );

  // NOTE: every signal driven here gets a default before the case, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_VSYNC;
          cnt_load = 1'b1;
        end
      end
      ST_VSYNC: begin
        cnt_term = VSYNC_TERM;
        if (cnt_tc) begin
          state_d  = ST_HBLANK;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HBLANK: begin
        cnt_term = HBLANK_TERM;
        if (cnt_tc) begin
          state_d  = ST_DATA;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DATA: begin
        cnt_term = DATA_TERM;
        if (cnt_tc) begin
          state_d  = (row == LAST_ROW) ? ST_DONE : ST_HBLANK;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        cnt_load = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_load = 1'b1;
      end
    endcase
    // Abort overrides every phase but IDLE, where start keeps priority.
    if (stop && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
      cnt_en   = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      vertical_Pulse   <= 1'b0;
      horizontal_Pulse <= 1'b0;
      busy             <= 1'b0;
      frame_Done       <= 1'b0;
      pixel_Addr       <= '0;
      row              <= '0;
      row_base         <= '0;
    end else begin
      state_q          <= state_d;
      vertical_Pulse   <= (state_d == ST_VSYNC);
      horizontal_Pulse <= (state_d == ST_DATA);
      busy             <= (state_d != ST_IDLE);
      frame_Done       <= (state_d == ST_DONE);

      if (state_q == ST_IDLE && start) begin
        row      <= '0;
        row_base <= '0;
      end else if (state_q == ST_DATA && state_d == ST_HBLANK) begin
        row      <= row + ROW_W'(1);
        row_base <= row_base + ADDR_W'(IMAGE_WIDTH);
      end

      if (state_d == ST_DATA) begin
        pixel_Addr <= (state_q == ST_DATA) ? pixel_Addr + ADDR_W'(2) : row_base;
      end
    end
  end

endmodule
